sram_arbiter: RTL and testbench

Shares the single SRAM data port between the CPU data-memory stage and a second bus master (DMA/program loader). It arbitrates between the two requesters, latches the winning request and drives the SRAM for a programmable number of cycles. It returns read data with a one-cycle acknowledge and stalls the CPU while its access is pending. It sits between `CPU` and `SRAM` in the top level; the tri-state data bus is resolved outside the block.

---
 rtl/sram_arb_pkg.sv | 13 +
 rtl/sram_arb_pick.sv | 37 +++
 rtl/sram_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and requester ids for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-way request picker: round-robin by default, fixed CPU priority
// when SRAM_ARB_CPU_PRIORITY_EN is defined.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Choose the winner among the currently asserted requests.
    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_id    = REQ_CPU;
`ifdef SRAM_ARB_CPU_PRIORITY_EN
        if (cpu_req) begin
            grant_id = REQ_CPU;
        end else if (dma_req) begin
            grant_id = REQ_DMA;
        end else begin
            grant_id = REQ_CPU;
        end
`else
        // On a tie the requester that did not win last time goes next.
        if (cpu_req && dma_req) begin
            grant_id = ~last_grant;
        end else if (dma_req) begin
            grant_id = REQ_DMA;
        end else begin
            grant_id = REQ_CPU;
        end
`endif
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM port between the CPU data stage and a DMA master.
// Build option SRAM_ARB_CPU_PRIORITY_EN switches ties to fixed CPU priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] sramA,
    output logic              sramWe,
    output logic              sramRe,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_drive,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

    state_t            state_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              id_r;
    logic              last_grant_r;
    logic              grant_valid_s;
    logic              grant_id_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    sram_arb_pick u_pick (
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Route the winning requester's fields toward the latch registers.
    always_comb begin
        if (grant_id_s == REQ_DMA) begin
            sel_we_s    = dma_we;
            sel_addr_s  = dma_addr;
            sel_wdata_s = dma_wdata;
        end else begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_ack;

    // Access sequencer; SRAM controls and acks are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            wait_cnt_r   <= '0;
            id_r         <= REQ_CPU;
            last_grant_r <= REQ_DMA;
            sramA        <= '0;
            sramWe       <= 1'b0;
            sramRe       <= 1'b0;
            sram_drive   <= 1'b0;
            sram_wdata   <= '0;
            cpu_ack      <= 1'b0;
            dma_ack      <= 1'b0;
            cpu_rdata    <= '0;
            dma_rdata    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    if (grant_valid_s) begin
                        id_r         <= grant_id_s;
                        last_grant_r <= grant_id_s;
                        sramA        <= sel_addr_s;
                        sramWe       <= sel_we_s;
                        sramRe       <= ~sel_we_s;
                        sram_drive   <= sel_we_s;
                        sram_wdata   <= sel_wdata_s;
                        wait_cnt_r   <= WS_INIT;
                        state_r      <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (wait_cnt_r != '0) begin
                        wait_cnt_r <= wait_cnt_r - CNT_W'(1);
                    end else begin
                        // sramRe doubles as the latched "this is a read" flag.
                        if (sramRe) begin
                            if (id_r == REQ_CPU) begin
                                cpu_rdata <= sram_rdata;
                            end else begin
                                dma_rdata <= sram_rdata;
                            end
                        end
                        if (id_r == REQ_CPU) begin
                            cpu_ack <= 1'b1;
                        end else begin
                            dma_ack <= 1'b1;
                        end
                        sramWe     <= 1'b0;
                        sramRe     <= 1'b0;
                        sram_drive <= 1'b0;
                        state_r    <= DONE;
                    end
                end
                DONE: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    sramWe     <= 1'b0;
                    sramRe     <= 1'b0;
                    sram_drive <= 1'b0;
                    cpu_ack    <= 1'b0;
                    dma_ack    <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbitration rules.
module tb_sram_arbiter;

    localparam int WS = 1;

    logic        clk, rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, sramA, sram_wdata, sram_rdata;
    logic        cpu_ack, dma_ack, cpu_stall, sramWe, sramRe, sram_drive;
    logic [31:0] cpu_rdata_z, dma_rdata_z, sramA_z, sram_wdata_z, sram_rdata_z;
    logic        cpu_ack_z, dma_ack_z, cpu_stall_z, sramWe_z, sramRe_z, sram_drive_z;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        mem_ld;
    logic [3:0]  mem_idx;
    logic [31:0] mem_val;

    sram_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .sramA(sramA), .sramWe(sramWe), .sramRe(sramRe), .sram_wdata(sram_wdata),
        .sram_drive(sram_drive), .sram_rdata(sram_rdata)
    );

    sram_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_z), .cpu_ack(cpu_ack_z), .cpu_stall(cpu_stall_z),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata_z), .dma_ack(dma_ack_z),
        .sramA(sramA_z), .sramWe(sramWe_z), .sramRe(sramRe_z), .sram_wdata(sram_wdata_z),
        .sram_drive(sram_drive_z), .sram_rdata(sram_rdata_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM behavioural model seen by the main instance.
    assign sram_rdata = mem[sramA[3:0]];
    always @(posedge clk) begin
        if (mem_ld) mem[mem_idx] <= mem_val;
        else if (sramWe) mem[sramA[3:0]] <= sram_wdata;
    end

    function automatic logic [31:0] mem_default(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
        cpu_addr = 32'h0; dma_addr = 32'h0; cpu_wdata = 32'h0; dma_wdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            mem_ld = 1'b1; mem_idx = 4'(i); mem_val = mem_default(i);
            ref_mem[i] = mem_default(i);
            @(negedge clk);
        end
        mem_ld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic mem_write(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        mem_ld = 1'b1; mem_idx = idx; mem_val = val; ref_mem[idx] = val;
        @(negedge clk);
        mem_ld = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++; if ({sramWe, sramRe, sram_drive, cpu_ack, dma_ack} !== 5'b0) begin errors++;
            $display("FAIL rst_ctrl got %b exp 00000", {sramWe, sramRe, sram_drive, cpu_ack, dma_ack}); end
        checks++; if (sramA !== 32'h0 || sram_wdata !== 32'h0) begin errors++;
            $display("FAIL rst_bus got %h/%h exp 0/0", sramA, sram_wdata); end
        checks++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin errors++;
            $display("FAIL rst_rdata got %h/%h exp 0/0", cpu_rdata, dma_rdata); end
        checks++; if (cpu_stall !== 1'b1) begin errors++;
            $display("FAIL rst_stall_hi got %b exp 1", cpu_stall); end
        cpu_req = 1'b0; #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++;
            $display("FAIL rst_stall_lo got %b exp 0", cpu_stall); end
        do_reset();
    endtask

    task automatic test_cpu_read();
        do_reset();
        mem_write(4'h0, 32'hDEADBEEF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; end
            #1;
            checks++; if (sramRe !== (c == 1 || c == 2) || sramWe !== 1'b0) begin errors++;
                $display("FAIL rd_en c%0d got re=%b we=%b", c, sramRe, sramWe); end
            checks++; if (cpu_ack !== (c == 3)) begin errors++;
                $display("FAIL rd_ack c%0d got %b exp %b", c, cpu_ack, c == 3); end
            checks++; if (cpu_stall !== (c <= 2)) begin errors++;
                $display("FAIL rd_stall c%0d got %b exp %b", c, cpu_stall, c <= 2); end
            if (c == 1 || c == 2) begin
                checks++; if (sramA !== 32'h10) begin errors++;
                    $display("FAIL rd_addr c%0d got %h exp 00000010", c, sramA); end
            end
            if (c >= 3) begin
                checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++;
                    $display("FAIL rd_data c%0d got %h exp deadbeef", c, cpu_rdata); end
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_dma_write();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h12345678; end
            #1;
            checks++; if (sramWe !== (c == 1 || c == 2) || sram_drive !== sramWe || sramRe !== 1'b0) begin errors++;
                $display("FAIL wr_en c%0d got we=%b drv=%b re=%b", c, sramWe, sram_drive, sramRe); end
            checks++; if (dma_ack !== (c == 3) || cpu_ack !== 1'b0) begin errors++;
                $display("FAIL wr_ack c%0d got %b exp %b", c, dma_ack, c == 3); end
            if (c == 1 || c == 2) begin
                checks++; if (sramA !== 32'h20 || sram_wdata !== 32'h12345678) begin errors++;
                    $display("FAIL wr_bus c%0d got %h/%h exp 20/12345678", c, sramA, sram_wdata); end
            end
            if (c >= 3) begin
                checks++; if (dma_rdata !== 32'h0) begin errors++;
                    $display("FAIL wr_rdata c%0d got %h exp 0", c, dma_rdata); end
                dma_req = 1'b0;
            end
        end
    endtask

    task automatic test_both_continuous();
        logic e_c, e_d;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1;
                dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h2;
            end
            #1;
`ifdef SRAM_ARB_CPU_PRIORITY_EN
            e_c = (c % 4 == 3); e_d = 1'b0;
`else
            e_c = (c % 8 == 3); e_d = (c % 8 == 7);
`endif
            checks++; if (cpu_ack !== e_c || dma_ack !== e_d) begin errors++;
                $display("FAIL both_ack c%0d got %b%b exp %b%b", c, cpu_ack, dma_ack, e_c, e_d); end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    task automatic test_addr_change();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hAAAA5555; end
            if (c == 1) begin cpu_addr = 32'h44; cpu_wdata = 32'h0F0F0F0F; cpu_we = 1'b0; end
            #1;
            if (c == 1 || c == 2) begin
                checks++; if (sramA !== 32'h30 || sram_wdata !== 32'hAAAA5555 || sramWe !== 1'b1) begin errors++;
                    $display("FAIL latch c%0d got %h/%h/%b exp 30/aaaa5555/1", c, sramA, sram_wdata, sramWe); end
            end
            if (c == 3) begin
                checks++; if (cpu_ack !== 1'b1) begin errors++;
                    $display("FAIL latch_ack got %b exp 1", cpu_ack); end
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 0) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14; end
            if (c == 2) begin rst = 1'b0; cpu_req = 1'b0; end
            if (c == 6) cpu_req = 1'b1;
            #1;
            if (c == 1) begin
                checks++; if (sramRe !== 1'b1) begin errors++;
                    $display("FAIL mid_pre got %b exp 1", sramRe); end
                rst = 1'b1;
            end
            if (c >= 2 && c <= 5) begin
                checks++; if ({sramWe, sramRe, sram_drive, cpu_ack, dma_ack} !== 5'b0) begin errors++;
                    $display("FAIL mid_abort c%0d got %b exp 00000", c, {sramWe, sramRe, sram_drive, cpu_ack, dma_ack}); end
            end
            if (c >= 6) begin
                checks++; if (cpu_ack !== (c == 9)) begin errors++;
                    $display("FAIL mid_retry_ack c%0d got %b exp %b", c, cpu_ack, c == 9); end
            end
            if (c == 9) begin
                checks++; if (cpu_rdata !== mem_default(4)) begin errors++;
                    $display("FAIL mid_retry_data got %h exp %h", cpu_rdata, mem_default(4)); end
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_ws0();
        do_reset();
        sram_rdata_z = 32'hA5A50F0F;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8; end
            #1;
            checks++; if (sramRe_z !== (c == 1) || cpu_ack_z !== (c == 2)) begin errors++;
                $display("FAIL ws0 c%0d got re=%b ack=%b", c, sramRe_z, cpu_ack_z); end
            if (c == 2) begin
                checks++; if (cpu_rdata_z !== 32'hA5A50F0F) begin errors++;
                    $display("FAIL ws0_data got %h exp a5a50f0f", cpu_rdata_z); end
                cpu_req = 1'b0;
            end
        end
    endtask

    // Transaction-level model: one access at a time, start cycle s,
    // drive cycles s+1..s+WS+1, ack at s+WS+2, next grant from s+WS+3.
    task automatic test_random();
        int s = 0;
        bit act = 1'b0, last = 1'b1, tid = 1'b0, twe = 1'b0;
        bit c_ackp = 1'b0, d_ackp = 1'b0, in_acc, e_ca, e_da;
        logic [31:0] taddr = 32'h0, twd = 32'h0, e_crd = 32'h0, e_drd = 32'h0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!cpu_req) cpu_req = ($urandom_range(3) == 0);
            else if (c_ackp) cpu_req = 1'($urandom_range(1));
            if (!dma_req) dma_req = ($urandom_range(3) == 0);
            else if (d_ackp) dma_req = 1'($urandom_range(1));
            cpu_we = 1'($urandom_range(1)); dma_we = 1'($urandom_range(1));
            cpu_wdata = $urandom(); dma_wdata = $urandom();
            cpu_addr = ($urandom_range(7) == 0) ? $urandom() : 32'($urandom_range(15));
            dma_addr = ($urandom_range(7) == 0) ? $urandom() : 32'($urandom_range(15));
            #1;
            in_acc = act && n >= s + 1 && n <= s + WS + 1;
            e_ca = act && n == s + WS + 2 && tid == 1'b0;
            e_da = act && n == s + WS + 2 && tid == 1'b1;
            if (act && n == s + WS + 2) begin
                if (twe) ref_mem[taddr[3:0]] = twd;
                else if (tid == 1'b0) e_crd = ref_mem[taddr[3:0]];
                else e_drd = ref_mem[taddr[3:0]];
            end
            checks++; if (sramWe !== (in_acc && twe) || sramRe !== (in_acc && !twe) || sram_drive !== (in_acc && twe)) begin
                errors++; $display("FAIL rnd_en n%0d got we=%b re=%b drv=%b", n, sramWe, sramRe, sram_drive); end
            if (in_acc) begin
                checks++; if (sramA !== taddr || (twe && sram_wdata !== twd)) begin errors++;
                    $display("FAIL rnd_bus n%0d got %h/%h exp %h/%h", n, sramA, sram_wdata, taddr, twd); end
            end
            checks++; if (cpu_ack !== e_ca || dma_ack !== e_da) begin errors++;
                $display("FAIL rnd_ack n%0d got %b%b exp %b%b", n, cpu_ack, dma_ack, e_ca, e_da); end
            checks++; if (cpu_rdata !== e_crd || dma_rdata !== e_drd) begin errors++;
                $display("FAIL rnd_rdata n%0d got %h/%h exp %h/%h", n, cpu_rdata, dma_rdata, e_crd, e_drd); end
            checks++; if (cpu_stall !== (cpu_req && !e_ca)) begin errors++;
                $display("FAIL rnd_stall n%0d got %b exp %b", n, cpu_stall, cpu_req && !e_ca); end
            c_ackp = e_ca; d_ackp = e_da;
            if ((!act || n >= s + WS + 3) && (cpu_req || dma_req)) begin
`ifdef SRAM_ARB_CPU_PRIORITY_EN
                tid = !cpu_req;
`else
                tid = (cpu_req && dma_req) ? !last : !cpu_req;
`endif
                last = tid; s = n; act = 1'b1;
                twe   = tid ? dma_we : cpu_we;
                taddr = tid ? dma_addr : cpu_addr;
                twd   = tid ? dma_wdata : cpu_wdata;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_ld = 1'b0; mem_idx = 4'h0; mem_val = 32'h0; sram_rdata_z = 32'h0;
        cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
        cpu_addr = 32'h0; dma_addr = 32'h0; cpu_wdata = 32'h0; dma_wdata = 32'h0;
        do_reset();
        test_cpu_read();
        test_reset();
        test_dma_write();
        test_both_continuous();
        test_addr_change();
        test_reset_mid_access();
        test_ws0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
